// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with prescaler, wrap pulse and a digit-scan
// output (one-hot select, selected nibble, leading-zero blank) for a 7-seg mux.
module bcd_scan_counter #(
    parameter int N_DIGITS  = 8,
    parameter int COUNT_DIV = 1,
    parameter int BLANK_LZ  = 1
) (
    input  logic                  clk_1hz,
    input  logic                  rstb,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
    output logic [4*N_DIGITS-1:0] value,
    output logic                  wrap,
    output logic [N_DIGITS-1:0]   digit,
    output logic [3:0]            num,
    output logic                  blank
);

    localparam int              IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0]      PRE_LAST = 8'(COUNT_DIV - 1);

    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      sel;
    logic [7:0]            pre;
    logic                  step;
    logic [4*N_DIGITS-1:0] load_sat;
    logic [4*N_DIGITS-1:0] inc_val;
    logic [4*N_DIGITS-1:0] dec_val;
    logic [4*N_DIGITS-1:0] shifted;
    logic                  carry;
    logic                  borrow;
    logic                  lz;

    assign step = en && (pre == PRE_LAST);

    // Saturated load value plus ripple increment/decrement of the whole count.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        load_sat = '0;
        inc_val  = value;
        dec_val  = value;
        carry    = 1'b1;
        borrow   = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            load_sat[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd9 : load_val[4*k +: 4];
            if (carry) begin
                if (value[4*k +: 4] == 4'd9) begin
                    inc_val[4*k +: 4] = 4'd0;
                end else begin
                    inc_val[4*k +: 4] = value[4*k +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (value[4*k +: 4] == 4'd0) begin
                    dec_val[4*k +: 4] = 4'd9;
                end else begin
                    dec_val[4*k +: 4] = value[4*k +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_1hz or negedge rstb) begin
        if (!rstb) begin
            value <= '0;
            wrap  <= 1'b0;
            pre   <= '0;
            idx   <= '0;
        end else begin
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            wrap <= 1'b0;
            if (clr) begin
                value <= '0;
                pre   <= '0;
            end else if (load) begin
                value <= load_sat;
                pre   <= '0;
            end else if (en) begin
                if (step) begin
                    pre   <= '0;
                    value <= up ? inc_val : dec_val;
                    wrap  <= up ? carry : borrow;
                end else begin
                    pre <= pre + 8'd1;
                end
            end
        end
    end

    // idx 0 selects the most-significant position; sel is the nibble index shown.
    always_comb begin
        sel     = IDX_LAST - idx;
        digit   = N_DIGITS'(1) << sel;
        shifted = value >> {sel, 2'b00};
        num     = shifted[3:0];
        lz      = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if ((IDX_W'(k) >= sel) && (value[4*k +: 4] != 4'd0)) begin
                lz = 1'b0;
            end
        end
        blank = (BLANK_LZ != 0) && lz && (sel != '0);
    end

endmodule
